// File: rtl/mips_pkg.sv
// Shared MIPS encodings and hazard-controller state type for the 5-stage pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction now in ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    output logic        hit
);

    logic [5:0] id_op;
    logic [5:0] ex_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       rs_use;
    logic       rt_use;
    logic       unused_bits;

    assign id_op = id_instr[31:26];
    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];
    assign ex_op = ex_instr[31:26];
    assign ex_rt = ex_instr[20:16];

    // A jump reads no registers; rt is only a source for R-type and sw.
    assign rs_use = (ex_rt == id_rs) && (id_op != OP_J);
    assign rt_use = (ex_rt == id_rt) && ((id_op == OP_RTYPE) || (id_op == OP_SW));

    assign hit = (ex_op == OP_LW) && (ex_rt != 5'd0) && (rs_use || rt_use);

    assign unused_bits = ^{id_instr[15:0], ex_instr[25:21], ex_instr[15:0]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes and data-memory freezes
// for the 5-stage MIPS datapath, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_MAX     = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      ex_instr,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [FW-1:0]    FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0]    WAIT_LIMIT   = WW'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    hz_state_t     state, state_nx;
    logic [FW-1:0] flush_ctr, flush_nx;
    logic [WW-1:0] wait_ctr, wait_nx;
    logic          redirect_pend, pend_nx;
    logic          timeout_nx;
    logic          hit;
    logic          pc_en_c, ifid_en_c, idex_en_c, flush_c, bubble_c;

    load_use_detect u_lud (
        .id_instr (id_instr),
        .ex_instr (ex_instr),
        .hit      (hit)
    );

    always_comb begin
        state_nx   = state;
        flush_nx   = flush_ctr;
        wait_nx    = wait_ctr;
        pend_nx    = redirect_pend;
        timeout_nx = mem_timeout;
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        idex_en_c  = 1'b1;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = FLUSH;
                        flush_nx = FLUSH_RELOAD;
                    end
                end else if (mem_req && !mem_ready) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_en_c = 1'b0;
                    state_nx  = MEM_WAIT;
                    wait_nx   = WW'(1);
                end else if (hit) begin
                    // EX receives a bubble, so the hazard is gone next cycle.
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    bubble_c  = 1'b1;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (redirect) begin
                    flush_nx = FLUSH_RELOAD;
                end else if (flush_ctr <= FW'(1)) begin
                    flush_nx = '0;
                    state_nx = RUN;
                end else begin
                    flush_nx = flush_ctr - FW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    wait_nx  = '0;
                    pend_nx  = 1'b0;
                    state_nx = RUN;
                    // A redirect seen while frozen takes effect on the release cycle.
                    if (redirect_pend || redirect) begin
                        flush_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nx = FLUSH;
                            flush_nx = FLUSH_RELOAD;
                        end
                    end
                end else begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_en_c = 1'b0;
                    if (redirect) pend_nx = 1'b1;
                    if (wait_ctr == WAIT_LIMIT) timeout_nx = 1'b1;
                    else                        wait_nx    = wait_ctr + WW'(1);
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign pc_en       = rst ? 1'b0 : pc_en_c;
    assign ifid_en     = rst ? 1'b0 : ifid_en_c;
    assign idex_en     = rst ? 1'b0 : idex_en_c;
    assign ifid_flush  = rst ? 1'b1 : flush_c;
    assign idex_bubble = rst ? 1'b1 : bubble_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            flush_ctr     <= '0;
            wait_ctr      <= '0;
            redirect_pend <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state         <= state_nx;
            flush_ctr     <= flush_nx;
            wait_ctr      <= wait_nx;
            redirect_pend <= pend_nx;
            mem_timeout   <= timeout_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, flushes, memory waits and reset.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en, ifid_en, idex_en, ifid_flush, idex_bubble;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic [4:0]  outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble}
    localparam logic [4:0] O_RUN   = 5'b11100;
    localparam logic [4:0] O_LU    = 5'b00101;
    localparam logic [4:0] O_FLUSH = 5'b11111;
    localparam logic [4:0] O_FRZ   = 5'b00000;
    localparam logic [4:0] O_RST   = 5'b00011;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .WAIT_MAX(15), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_instr    (id_instr),
        .ex_instr    (ex_instr),
        .redirect    (redirect),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt)
    );

    assign outs = {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_instr  = 32'h0;
        ex_instr  = 32'h0;
        redirect  = 1'b0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        n_checks++;
        if (outs !== O_RST) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
        n_checks++;
        if (stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: stall_cnt=%0d timeout=%b want 0/0", stall_cnt, mem_timeout);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL post_reset_run: got %b want %b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        s0 = stall_cnt;
        ex_instr = itype(6'h23, 5'd1, 5'd2);              // lw $2,4($1)
        id_instr = rtype(5'd2, 5'd4, 5'd3, 6'h23);        // subu $3,$2,$4
        @(negedge clk);
        n_checks++;
        if (outs !== O_LU) begin n_fail++; $display("FAIL lu_rs_stall: got %b want %b", outs, O_LU); end
        next_cycle();
        ex_instr = 32'h0;                                 // bubble now in EX
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL lu_resume: got %b want %b", outs, O_RUN); end
        n_checks++;
        if (stall_cnt !== s0 + 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, s0 + 16'd1); end
        next_cycle();
        ex_instr = itype(6'h23, 5'd1, 5'd2);
        id_instr = itype(6'h2b, 5'd5, 5'd2);              // sw $2,4($5): rt is a source
        @(negedge clk);
        n_checks++;
        if (outs !== O_LU) begin n_fail++; $display("FAIL lu_sw_rt: got %b want %b", outs, O_LU); end
        next_cycle();
        id_instr = itype(6'h08, 5'd7, 5'd2);              // addi $2,$7,4: rt is a destination
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL lu_addi_rt: got %b want %b", outs, O_RUN); end
        next_cycle();
        idle();
    endtask

    task automatic test_no_stall();
        ex_instr = itype(6'h23, 5'd1, 5'd0);              // lw $0,4($1)
        id_instr = rtype(5'd0, 5'd0, 5'd3, 6'h21);
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL ns_rt_zero: got %b want %b", outs, O_RUN); end
        next_cycle();
        ex_instr = itype(6'h23, 5'd1, 5'd5);              // lw $5,4($1)
        id_instr = {6'h02, 5'd5, 5'd5, 16'h0000};         // j whose target bits alias $5
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL ns_jump: got %b want %b", outs, O_RUN); end
        next_cycle();
        idle();
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL rd_cycle1: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        redirect = 1'b0;
        ex_instr = itype(6'h23, 5'd1, 5'd2);              // load-use ignored while flushing
        id_instr = rtype(5'd2, 5'd4, 5'd3, 6'h23);
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL rd_cycle2: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL rd_done: got %b want %b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1;
        next_cycle();
        @(negedge clk);                                   // second redirect in FLUSH reloads
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL b2b_reload: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL b2b_extra: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL b2b_done: got %b want %b", outs, O_RUN); end
        next_cycle();
        redirect  = 1'b1;                                 // redirect outranks a memory wait
        mem_req   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL prio_redirect: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_mem_wait();
        logic [15:0] s0;
        s0 = stall_cnt;
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== O_FRZ) begin n_fail++; $display("FAIL mw_freeze%0d: got %b want %b", i, outs, O_FRZ); end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL mw_resume: got %b want %b", outs, O_RUN); end
        n_checks++;
        if (stall_cnt !== s0 + 16'd3) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d want %0d", stall_cnt, s0 + 16'd3); end
        next_cycle();
        @(negedge clk);                                   // req with ready same cycle: no stall
        n_checks++;
        if (outs !== O_RUN || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mw_ready_hit: got %b/%b want %b/0", outs, mem_timeout, O_RUN);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_timeout();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early%0d: got %b want 0", i, mem_timeout); end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_timeout !== 1'b1 || outs !== O_RUN) begin
            n_fail++; $display("FAIL to_set: got %b/%b want 1/%b", mem_timeout, outs, O_RUN);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL to_rst_clear: timeout=%b stall_cnt=%0d want 0/0", mem_timeout, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_redirect_in_wait();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FRZ) begin n_fail++; $display("FAIL rw_enter: got %b want %b", outs, O_FRZ); end
        next_cycle();
        redirect = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FRZ) begin n_fail++; $display("FAIL rw_held: got %b want %b", outs, O_FRZ); end
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL rw_apply: got %b want %b", outs, O_FLUSH); end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL rw_flush2: got %b want %b", outs, O_FLUSH); end
        #2 rst = 1'b1;                                    // async reset mid-FLUSH
        #1;
        n_checks++;
        if (outs !== O_RST || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rw_async_rst: outs=%b stall_cnt=%0d want %b/0", outs, stall_cnt, O_RST);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_RUN) begin n_fail++; $display("FAIL rw_restart_run: got %b want %b", outs, O_RUN); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_redirect_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
